// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for dcache_ctrl.
// DCACHE_STATS_EN adds the hit/miss counter outputs.
interface dcache_ctrl_if;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  // Cache controller side.
  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
`ifdef DCACHE_STATS_EN
    output hit_cnt_o, miss_cnt_o,
`endif
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  // CPU pipeline plus memory side.
  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
`ifdef DCACHE_STATS_EN
    input  hit_cnt_o, miss_cnt_o,
`endif
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller with 256-bit lines.
// Optional DCACHE_STATS_EN adds wrapping hit/miss counters.
module dcache_ctrl #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_ctrl_if.slave bus
);
  localparam int unsigned Sets    = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 27 - INDEX_BITS;

  typedef enum logic [1:0] {StIdle, StWriteback, StReadMiss, StRefill} state_e;

  state_e                state_q;
  logic [TagBits-1:0]    tag_q  [Sets];
  logic [255:0]          data_q [Sets];
  logic [Sets-1:0]       valid_q, dirty_q;
  logic [TagBits-1:0]    fill_tag_q;
  logic [INDEX_BITS-1:0] fill_idx_q;
  logic [255:0]          fill_line_q;
  logic                  mem_enable_q, mem_write_q;
  logic [31:0]           mem_addr_q;
  logic [255:0]          mem_data_q;

  logic [TagBits-1:0]    req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [2:0]            req_word;
  logic                  idle, hit, miss;

  assign req_word = bus.cpu_addr_i[4:2];
  assign req_idx  = bus.cpu_addr_i[4+INDEX_BITS:5];
  assign req_tag  = bus.cpu_addr_i[31:5+INDEX_BITS];
  assign idle     = (state_q == StIdle);
  assign hit      = idle & bus.cpu_req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign miss     = idle & bus.cpu_req_i & ~hit;

  assign bus.cpu_data_o   = hit ? data_q[req_idx][{req_word, 5'd0} +: 32] : '0;
  // Gated by reset so stall drops asynchronously even while a request is held.
  assign bus.cpu_stall_o  = rst_i & (miss | ~idle);
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      dirty_q      <= '0;
      fill_tag_q   <= '0;
      fill_idx_q   <= '0;
      fill_line_q  <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss) begin
            // Latch the request so the fill completes even if the CPU drops it.
            fill_tag_q   <= req_tag;
            fill_idx_q   <= req_idx;
            mem_enable_q <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q     <= StWriteback;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[req_idx], req_idx, 5'b0};
              mem_data_q  <= data_q[req_idx];
            end else begin
              state_q     <= StReadMiss;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_idx, 5'b0};
            end
          end else if (hit && bus.cpu_write_i) begin
            dirty_q[req_idx] <= 1'b1;
          end
        end
        StWriteback: begin
          if (bus.mem_ack_i) begin
            state_q     <= StReadMiss;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {fill_tag_q, fill_idx_q, 5'b0};
          end
        end
        StReadMiss: begin
          if (bus.mem_ack_i) begin
            state_q      <= StRefill;
            fill_line_q  <= bus.mem_data_i;
            mem_enable_q <= 1'b0;
          end
        end
        StRefill: begin
          state_q             <= StIdle;
          valid_q[fill_idx_q] <= 1'b1;
          dirty_q[fill_idx_q] <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (hit && bus.cpu_write_i) begin
      data_q[req_idx][{req_word, 5'd0} +: 32] <= bus.cpu_data_i;
    end
    if (state_q == StRefill) begin
      data_q[fill_idx_q] <= fill_line_q;
      tag_q[fill_idx_q]  <= fill_tag_q;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_prev_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // The hit that replays a just-filled request is not counted as a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refill_prev_q <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      refill_prev_q <= (state_q == StRefill);
      if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (hit && !refill_prev_q) hit_cnt_q <= hit_cnt_q + 32'd1;
    end
  end

  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: transaction-level cache/memory model plus per-cycle compare.
// Also checks counters when built with DCACHE_STATS_EN.
module tb_dcache_ctrl;
  localparam int IB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_ctrl_if bus_if ();

  dcache_ctrl #(.INDEX_BITS(IB)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if)
  );

  // Behavioural model: line-granular memory and the cache contents it implies.
  logic [255:0] mem_m [logic [26:0]];
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_data  [16];
  int unsigned  m_hits, m_misses;

  // Per-cycle expectations consumed by the compare process.
  bit           chk_en;
  bit           e_stall, e_en, e_wr, e_rd_chk;
  logic [31:0]  e_addr, e_rdata;
  logic [255:0] e_wdata;

  int           n_tests, n_fail;
  int           stall_seen;
  logic [31:0]  last_rdata, wb_addr_seen;
  logic [255:0] wb_line_seen;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [255:0] get_line(logic [26:0] ln);
    if (!mem_m.exists(ln)) mem_m[ln] = rand_line();
    return mem_m[ln];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("stall", 256'(bus_if.cpu_stall_o), 256'(e_stall));
      check("mem_enable", 256'(bus_if.mem_enable_o), 256'(e_en));
      if (e_en) begin
        check("mem_write", 256'(bus_if.mem_write_o), 256'(e_wr));
        check("mem_addr", 256'(bus_if.mem_addr_o), 256'(e_addr));
        if (e_wr) check("mem_wdata", bus_if.mem_data_o, e_wdata);
      end
      if (e_rd_chk) check("load_data", 256'(bus_if.cpu_data_o), 256'(e_rdata));
`ifdef DCACHE_STATS_EN
      check("hit_cnt", 256'(bus_if.hit_cnt_o), 256'(m_hits));
      check("miss_cnt", 256'(bus_if.miss_cnt_o), 256'(m_misses));
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    if (bus_if.cpu_stall_o) stall_seen++;
    last_rdata = bus_if.cpu_data_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus_if.cpu_req_i = 1'b0;
    e_stall = 1'b0; e_en = 1'b0; e_rd_chk = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_if.mem_ack_i  = 1'($urandom_range(0, 1));  // ignored in IDLE
      bus_if.mem_data_i = rand_line();
      step();
    end
    bus_if.mem_ack_i = 1'b0;
  endtask

  // One CPU access; drop=1 releases the request right after miss detection.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input bit drop);
    logic [3:0]   idx;
    logic [22:0]  tg;
    int           w;
    logic [255:0] line;
    bit           hitm;
    idx = addr[8:5];
    tg  = addr[31:9];
    w   = int'(addr[4:2]);
    stall_seen = 0;
    bus_if.cpu_req_i   = 1'b1;
    bus_if.cpu_write_i = wr;
    bus_if.cpu_addr_i  = addr;
    bus_if.cpu_data_i  = wd;
    bus_if.mem_ack_i   = 1'b0;
    hitm = m_valid[idx] && (m_tag[idx] == tg);
    if (!hitm) begin
      e_stall = 1'b1; e_en = 1'b0; e_rd_chk = 1'b0;
      step();
      m_misses++;
      if (drop) begin
        bus_if.cpu_req_i   = 1'b0;
        bus_if.cpu_addr_i  = $urandom;
        bus_if.cpu_write_i = 1'($urandom_range(0, 1));
      end
      if (m_valid[idx] && m_dirty[idx]) begin
        e_en = 1'b1; e_wr = 1'b1; e_addr = {m_tag[idx], idx, 5'b0}; e_wdata = m_data[idx];
        for (int k = 1; k <= lat; k++) begin
          bus_if.mem_ack_i  = (k == lat);
          bus_if.mem_data_i = rand_line();
          if (k == lat) begin
            wb_addr_seen = bus_if.mem_addr_o;
            wb_line_seen = bus_if.mem_data_o;
          end
          step();
        end
        mem_m[{m_tag[idx], idx}] = m_data[idx];
      end
      line = get_line({tg, idx});
      e_en = 1'b1; e_wr = 1'b0; e_addr = {tg, idx, 5'b0};
      for (int k = 1; k <= lat; k++) begin
        bus_if.mem_ack_i  = (k == lat);
        bus_if.mem_data_i = (k == lat) ? line : rand_line();
        step();
      end
      e_en = 1'b0; e_stall = 1'b1;
      bus_if.mem_ack_i  = 1'($urandom_range(0, 1));  // ignored in REFILL
      bus_if.mem_data_i = rand_line();
      step();
      bus_if.mem_ack_i = 1'b0;
      m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_tag[idx] = tg; m_data[idx] = line;
      if (drop) begin
        idle_cycles(1);
        return;
      end
    end
    e_stall = 1'b0; e_en = 1'b0; e_rd_chk = !wr;
    e_rdata = m_data[idx][w*32 +: 32];
    bus_if.mem_ack_i = 1'($urandom_range(0, 1));
    step();
    if (wr) begin
      m_data[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
    if (hitm) m_hits++;
    bus_if.cpu_req_i = 1'b0;
    bus_if.mem_ack_i = 1'b0;
    e_rd_chk = 1'b0;
  endtask

  initial begin
    logic [255:0] l0;
    n_tests = 0; n_fail = 0; chk_en = 1'b0;
    e_stall = 1'b0; e_en = 1'b0; e_wr = 1'b0; e_rd_chk = 1'b0;
    e_addr = '0; e_rdata = '0; e_wdata = '0;
    model_reset();
    // Request held during reset: outputs must still show reset values.
    bus_if.cpu_req_i   = 1'b1;
    bus_if.cpu_write_i = 1'b0;
    bus_if.cpu_addr_i  = 32'h40;
    bus_if.cpu_data_i  = '0;
    bus_if.mem_data_i  = '0;
    bus_if.mem_ack_i   = 1'b0;
    #12;
    check("reset_stall", 256'(bus_if.cpu_stall_o), 256'(0));
    check("reset_enable", 256'(bus_if.mem_enable_o), 256'(0));
    check("reset_write", 256'(bus_if.mem_write_o), 256'(0));
    check("reset_addr", 256'(bus_if.mem_addr_o), 256'(0));
    check("reset_wdata", bus_if.mem_data_o, 256'(0));
    check("reset_rdata", 256'(bus_if.cpu_data_o), 256'(0));
    bus_if.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle_cycles(2);

    // Directed: clean miss, store hit, load hit, dirty-victim miss.
    l0 = rand_line();
    l0[31:0] = 32'h1111_1111;
    mem_m[27'h2] = l0;
    access(1'b0, 32'h0000_0040, '0, 10, 1'b0);
    check("clean_miss_stalls", 256'(stall_seen), 256'(12));
    check("clean_miss_data", 256'(last_rdata), 256'(32'h1111_1111));
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 10, 1'b0);
    check("store_hit_stalls", 256'(stall_seen), 256'(0));
    access(1'b0, 32'h0000_0044, '0, 10, 1'b0);
    check("load_hit_data", 256'(last_rdata), 256'(32'hDEAD_BEEF));
    access(1'b0, 32'h0000_0240, '0, 10, 1'b0);
    check("dirty_miss_stalls", 256'(stall_seen), 256'(22));
    check("wb_addr", 256'(wb_addr_seen), 256'(32'h40));
    check("wb_word1", 256'(wb_line_seen[63:32]), 256'(32'hDEAD_BEEF));
`ifdef DCACHE_STATS_EN
    check("stats_hits", 256'(bus_if.hit_cnt_o), 256'(2));
    check("stats_misses", 256'(bus_if.miss_cnt_o), 256'(2));
`endif

    // Reset during READMISS: memory request and stall drop at once.
    bus_if.cpu_req_i = 1'b1; bus_if.cpu_write_i = 1'b0; bus_if.cpu_addr_i = 32'h40;
    e_stall = 1'b1; e_en = 1'b0;
    step();
    e_en = 1'b1; e_wr = 1'b0; e_addr = 32'h40;
    step();
    step();
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_enable", 256'(bus_if.mem_enable_o), 256'(0));
    check("async_rst_stall", 256'(bus_if.cpu_stall_o), 256'(0));
    model_reset();
    bus_if.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle_cycles(1);
    access(1'b0, 32'h0000_0040, '0, 3, 1'b0);
    check("post_reset_miss_stalls", 256'(stall_seen), 256'(5));
    access(1'b0, 32'h0000_0044, '0, 3, 1'b0);
    check("post_reset_wb_data", 256'(last_rdata), 256'(32'hDEAD_BEEF));

    // Request dropped mid-miss: line still installed, later load hits.
    access(1'b0, 32'h0000_1180, '0, 4, 1'b1);
    access(1'b0, 32'h0000_1184, '0, 4, 1'b0);
    check("drop_then_hit_stalls", 256'(stall_seen), 256'(0));

    // Randomized traffic over a small tag pool to mix hits, clean and dirty misses.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = {21'($urandom_range(0, 3)), 2'b0, 4'($urandom), 3'($urandom), 2'b0};
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4),
             ($urandom_range(0, 9) == 0));
      idle_cycles($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
